// File: rtl/mem_burst_arbiter.sv
// Round-robin two-master burst arbiter in front of a shared sequential buffer.
// Tracks buffer occupancy locally and back-pressures the owning writer at DEPTH.
module mem_burst_arbiter #(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [LEN_W-1:0]  m0_len,
  output logic              m0_gnt,
  input  logic              m0_valid,
  input  logic [DATA_W-1:0] m0_data,
  output logic              m0_ready,
  input  logic              m1_req,
  input  logic [LEN_W-1:0]  m1_len,
  output logic              m1_gnt,
  input  logic              m1_valid,
  input  logic [DATA_W-1:0] m1_data,
  output logic              m1_ready,
  output logic              buf_wr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              buf_rd,
  input  logic              buf_empty,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [CNT_W-1:0]  occupancy,
  output logic              full,
  output logic              busy
);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [LEN_W-1:0]   beats_q, beats_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic               pick;
  logic               beat;

  assign busy      = (state_q == S_BURST);
  assign full      = (occ_q == CNT_W'(DEPTH));
  assign occupancy = occ_q;

  assign m0_gnt   = busy & ~owner_q;
  assign m1_gnt   = busy & owner_q;
  // ready looks only at grant and full, never at valid
  assign m0_ready = m0_gnt & ~full;
  assign m1_ready = m1_gnt & ~full;

  assign beat      = (m0_ready & m0_valid) | (m1_ready & m1_valid);
  assign buf_wr    = beat;
  assign buf_wdata = m1_gnt ? m1_data :
                     m0_gnt ? m0_data : '0;

  assign s_valid = ~buf_empty;
  assign buf_rd  = s_valid & s_ready;

  // on a tie the master that did not win last time goes next
  assign pick = (m0_req & m1_req) ? ~last_q : m1_req;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beats_d = beats_q;
    unique case (state_q)
      S_IDLE: begin
        if (m0_req | m1_req) begin
          state_d = S_BURST;
          owner_d = pick;
          beats_d = pick ? m1_len : m0_len;
        end
      end
      S_BURST: begin
        if (beat) begin
          if (beats_q == '0) begin
            state_d = S_IDLE;
            last_d  = owner_q;
          end else begin
            beats_d = beats_q - LEN_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    unique case (1'b1)
      (buf_wr & ~buf_rd):
        occ_d = occ_q + CNT_W'(1);
      (buf_rd & ~buf_wr & (occ_q != '0)):
        occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      beats_q <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beats_q <= beats_d;
      occ_q   <= occ_d;
    end
  end

endmodule

// File: doc/mem_burst_arbiter.md
# mem_burst_arbiter

Round-robin burst arbiter and flow controller in front of the shared 512-bit sequential buffer. It grants one of two write masters exclusive access for a whole burst and drives the buffer's `wr`/`wdata` strobes. It also drives the buffer's `rd` strobe from a single downstream consumer handshake. The buffer reports only `empty`, so this block tracks occupancy itself and back-pressures writers when a configured depth is reached.

## Interface
- `DATA_W`, 512, data beat width; must equal the buffer word width.
- `DEPTH`, 16, maximum words the controller allows resident in the buffer (1..65535).
- `LEN_W`, 8, width of the burst length field; length encodes beats-1, AXI style.
- `CNT_W`, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `m0_req`  in  1  master 0 burst request; level, held until granted.
- `m0_len`  in  LEN_W  master 0 beats-1; sampled at grant.
- `m0_gnt`  out  1  master 0 owns the buffer for the current burst.
- `m0_valid`  in  1  master 0 beat valid.
- `m0_data`  in  DATA_W  master 0 beat data.
- `m0_ready`  out  1  master 0 beat accepted when valid & ready.
- `m1_req`, `m1_len`, `m1_gnt`, `m1_valid`, `m1_data`, `m1_ready`: same as master 0.
- `buf_wr`  out  1  write strobe to the buffer.
- `buf_wdata`  out  DATA_W  write data to the buffer.
- `buf_rd`  out  1  read (pop) strobe to the buffer.
- `buf_empty`  in  1  buffer empty flag.
- `s_valid`  out  1  consumer data available (= !buf_empty).
- `s_ready`  in  1  consumer takes the current buffer head.
- `occupancy`  out  CNT_W  words currently held.
- `full`  out  1  occupancy == DEPTH.
- `busy`  out  1  FSM in BURST.

## Operation
- FSM states: IDLE, BURST.
- IDLE -> BURST when `m0_req | m1_req`.
  - Winner is picked by the priority pointer `last`: if both request, the master other than `last` wins; if one requests, that master wins.
  - On the transition, register the winner's `len` into `beats_left`, set the winner's `gnt`, and set `busy`.
- In BURST, the winner sees `mX_ready = !full`. The loser's `ready` and `gnt` are 0.
- A beat occurs when `mX_valid & mX_ready`:
  - `buf_wr = 1` in that cycle.
  - `buf_wdata = mX_data` (combinational mux by grant).
  - `beats_left` decrements.
- The beat taken with `beats_left == 0` is the last beat. On that edge:
  - move to IDLE;
  - clear `gnt` and `busy`;
  - set `last` to the winner.
- `req` changes during BURST are ignored. The length is latched and is not re-sampled.
- Read side: `s_valid = !buf_empty`; `buf_rd = s_valid & s_ready`.
- Occupancy:
  - +1 on `buf_wr` only; -1 on `buf_rd` only.
  - Unchanged when both occur, or when neither occurs.
  - `full = (occupancy == DEPTH)`.
- Full: `mX_ready` is 0 even if a read occurs in the same cycle. A write never depends on a same-cycle read.
- No write is issued when `occupancy == DEPTH`, so the counter never exceeds DEPTH and never underflows. `buf_rd` requires `!buf_empty`.
- Reset values:
  - state IDLE, `beats_left` 0, occupancy 0;
  - `last` = 1, so master 0 wins the first tie;
  - all outputs 0 except `s_valid`, which follows `buf_empty`.
- Reset mid-burst: the burst is abandoned immediately, with no completion beat. The buffer shares the same reset, so the occupancy of 0 stays consistent with it.

## Timing
- Grant latency: `req` seen in IDLE at edge N -> `gnt` high after edge N, so the first beat can complete at edge N+1.
- Burst of L+1 beats with continuous `valid` and no full condition: `gnt` is high for exactly L+1 cycles.
  - Back-to-back bursts have one IDLE cycle between them.
  - The next grant is visible one cycle after the last beat.
- `buf_wr`, `buf_wdata`, `buf_rd`, `mX_ready`, `s_valid` and `full` are combinational from registered state and inputs.
- `occupancy` updates on the edge after the strobe.
- `m*_ready` never depends on `m*_valid`, so there is no combinational loop through the masters.

## Test plan
- Reset, then `m0_req=1`, `m0_len=3`, `valid` held high, `s_ready=0`:
  - `m0_gnt` rises one cycle after `req`;
  - exactly 4 `buf_wr` pulses with data matching master 0;
  - occupancy ends at 4, then the FSM returns to IDLE.
- `m0_req` and `m1_req` high together, `len=0` each, requests held:
  - grants alternate m0, m1, m0, ... with one IDLE cycle between them;
  - the first grant goes to m0.
- DEPTH=16, `m1_len=19`, `s_ready=0`:
  - `m1_ready` drops after 16 beats and `full=1`;
  - pulsing `s_ready` for 1 cycle gives `buf_rd=1`; occupancy goes 16 -> 15 and `ready` reasserts the next cycle;
  - the burst completes after 4 total reads.
- Simultaneous write and read at occupancy 5 (`valid` and `s_ready` both high for 6 cycles): occupancy stays 5.
- At full with `s_ready=1`: `m_ready` stays 0 in that cycle and occupancy goes to 15.
- Assert `reset` during beat 2 of a 5-beat m1 burst:
  - `gnt`, `ready`, `busy` and `occupancy` go to 0 asynchronously;
  - after release, a new `m1_req` is granted with the full latched length.
- Master 0 de-asserts `valid` for 3 cycles mid-burst: no `buf_wr` is issued in those cycles, and the beat count and grant hold.
